// File: rtl/bmem_burst_responder_if.sv
// Burst memory bus between the cache-line arbiter (master)
// and the line-store responder (slave).
interface bmem_burst_responder_if;
  logic [31:0] addr;
  logic        read;
  logic        write;
  logic [63:0] wdata;
  logic        ready;
  logic [31:0] raddr;
  logic [63:0] rdata;
  logic        rvalid;

  modport master (
    output addr, read, write, wdata,
    input  ready, raddr, rdata, rvalid
  );

  modport slave (
    input  addr, read, write, wdata,
    output ready, raddr, rdata, rvalid
  );
endinterface

// File: rtl/bmem_burst_responder.sv
// Line-store memory responder: 4-beat line writes,
// latency-stamped in-order 4-beat line reads.
module bmem_burst_responder #(
  parameter int LINE_BITS    = 6,
  parameter int READ_LATENCY = 8,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  bmem_burst_responder_if.slave  bmem,
  output logic                   proto_err
);

  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int NL = 1 << LINE_BITS;

  typedef enum logic {W_IDLE, W_BEAT} w_state_e;
  typedef enum logic {R_IDLE, R_BEAT} r_state_e;

  w_state_e             w_state_q, w_state_d;
  logic [1:0]           n_q, n_d;
  logic [LINE_BITS-1:0] widx_q, widx_d;
  logic [191:0]         wbuf_q, wbuf_d;
  r_state_e             r_state_q, r_state_d;
  logic [1:0]           k_q, k_d;
  logic [255:0]         rline_q, rline_d;
  logic [26:0]          raddr_q, raddr_d;
  logic [QW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [QW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [QW:0]          count_q, count_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 perr_q, perr_d;

  logic [255:0] mem_q [NL] = '{default: '0};
  logic [26:0]  q_addr_q  [QUEUE_DEPTH];
  logic [15:0]  q_stamp_q [QUEUE_DEPTH];

  logic                 w_active;
  logic                 ready;
  logic                 push;
  logic                 wbeat0;
  logic                 commit;
  logic                 pop;
  logic                 head_elig;
  logic [255:0]         cline;
  logic [26:0]          head_laddr;
  logic [LINE_BITS-1:0] head_idx;
  logic [15:0]          head_age;
  logic                 unused_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      n_q       <= '0;
      widx_q    <= '0;
      wbuf_q    <= '0;
      r_state_q <= R_IDLE;
      k_q       <= '0;
      rline_q   <= '0;
      raddr_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cnt_q     <= '0;
      perr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      n_q       <= n_d;
      widx_q    <= widx_d;
      wbuf_q    <= wbuf_d;
      r_state_q <= r_state_d;
      k_q       <= k_d;
      rline_q   <= rline_d;
      raddr_q   <= raddr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      cnt_q     <= cnt_d;
      perr_q    <= perr_d;
    end
  end

  // Store and queue payload carry no reset; only pointers do.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem_q[widx_q] <= cline;
    end
    if (push) begin
      q_addr_q[wr_ptr_q]  <= bmem.addr[31:5];
      q_stamp_q[wr_ptr_q] <= cnt_q;
    end
  end

  always_comb begin
    push   = bmem.read & ready & ~w_active
           & ~bmem.write & ~rst;
    wbeat0 = ~w_active & bmem.write & ready;
    commit = w_active & bmem.write
           & (n_q == 2'd3) & ~rst;
    cline  = {bmem.wdata, wbuf_q};

    head_laddr = q_addr_q[rd_ptr_q];
    head_idx   = head_laddr[LINE_BITS-1:0];
    head_age   = cnt_q - q_stamp_q[rd_ptr_q];
    // Pop one cycle early so beat 0 lands at the latency.
    head_elig  = (count_q != '0)
               & (head_age >= 16'(READ_LATENCY - 1));
    pop        = head_elig
               & ((r_state_q == R_IDLE) | (k_q == 2'd3));

    w_state_d = w_state_q;
    n_d       = n_q;
    widx_d    = widx_q;
    wbuf_d    = wbuf_q;
    r_state_d = r_state_q;
    k_d       = k_q;
    rline_d   = rline_q;
    raddr_d   = raddr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q + 16'd1;

    unique case (w_state_q)
      W_IDLE: begin
        if (wbeat0) begin
          widx_d        = bmem.addr[5 +: LINE_BITS];
          wbuf_d[63:0]  = bmem.wdata;
          n_d           = 2'd1;
          w_state_d     = W_BEAT;
        end
      end
      W_BEAT: begin
        if (bmem.write) begin
          if (n_q == 2'd3) begin
            n_d       = 2'd0;
            w_state_d = W_IDLE;
          end else begin
            wbuf_d[{n_q, 6'd0} +: 64] = bmem.wdata;
            n_d = n_q + 2'd1;
          end
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    unique case (r_state_q)
      R_IDLE: begin
        if (pop) begin
          r_state_d = R_BEAT;
          k_d       = 2'd0;
        end
      end
      R_BEAT: begin
        if (k_q != 2'd3) begin
          k_d = k_q + 2'd1;
        end else if (pop) begin
          k_d = 2'd0;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    if (pop) begin
      // Bypass a line committing on this same edge.
      if (commit && (widx_q == head_idx)) begin
        rline_d = cline;
      end else begin
        rline_d = mem_q[head_idx];
      end
      raddr_d  = head_laddr;
      rd_ptr_d = rd_ptr_q + QW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + QW'(1);
    end
    count_d = count_q + (QW+1)'(push)
            - (QW+1)'(pop);

    perr_d = perr_q
           | (bmem.read & bmem.write & ~w_active)
           | (bmem.read & w_active)
           | (~ready & (bmem.read | bmem.write));
  end

  always_comb begin
    w_active    = (w_state_q == W_BEAT);
    ready       = w_active
                | (count_q < (QW+1)'(QUEUE_DEPTH));
    bmem.ready  = ready;
    bmem.rvalid = (r_state_q == R_BEAT);
    bmem.rdata  = '0;
    bmem.raddr  = '0;
    if (bmem.rvalid) begin
      bmem.rdata = rline_q[{k_q, 6'd0} +: 64];
      bmem.raddr = {raddr_q, 5'b0};
    end
    proto_err   = perr_q;
    unused_bits = ^bmem.addr[4:0];
  end

endmodule
